asteroid_stage_controller: RTL and testbench
============================================

# asteroid_stage_controller

Sequencer for the asteroid special stage: it resets and arms the asteroid field, runs an intro countdown, and gates asteroid motion while the stage is active. It counts destroyed asteroids, enforces a stage timer, and reports a single stage-done pulse with a win/lose result. It sits between the top-level game-flow logic and the asteroid field block, and drives that block's `enable` and local reset.

## Interface
Parameters:
- `ASTEROIDS_AMOUNT`, 4 — asteroids in the field; saturation value of `destroyed_count`.
- `INTRO_FRAMES`, 120 — frames spent in INTRO before motion starts.
- `FRAMES_PER_SECOND`, 60 — frame prescaler for the seconds timer.
- `STAGE_SECONDS`, 30 — stage time limit, in seconds.
- `OUTRO_FRAMES`, 60 — frames held in OUTRO before `stage_done`.

Ports:
- `clk` in 1 — system clock.
- `reset` in 1 — one clock; reset is asynchronous and active-high.
- `startOfFrame` in 1 — one-cycle pulse per video frame.
- `start_stage` in 1 — pulse; starts a stage from IDLE only.
- `pause` in 1 — level; freezes all timers and motion.
- `asteroid_exploded_pulse` in 1 — one-cycle pulse per newly hit asteroid.
- `all_asteroids_destroied` in 1 — level; every asteroid is deactivated.
- `player_hit` in 1 — pulse; the player collided with an asteroid.
- `asteroids_resetN` out 1 — active-low local reset for the asteroid field.
- `asteroids_enable` out 1 — motion enable for the asteroid field.
- `show_intro` out 1 — high during INTRO, for the overlay text.
- `stage_active` out 1 — high from CLEAR through OUTRO.
- `time_left` out 8 — remaining seconds.
- `destroyed_count` out 4 — asteroids destroyed this stage.
- `stage_done` out 1 — one-cycle pulse at stage end.
- `stage_won` out 1 — result; valid from OUTRO until the next start.

## Operation
- FSM states: IDLE, CLEAR, INTRO, ACTIVE, OUTRO, DONE.
- IDLE: outputs idle. On `start_stage`, go to CLEAR.
- CLEAR: lasts exactly 1 cycle.
  - `asteroids_resetN`=0.
  - Load `time_left`=STAGE_SECONDS, `destroyed_count`=0, `stage_won`=0, and both frame counters to 0.
  - Go to INTRO.
- INTRO: `show_intro`=1. Count `startOfFrame` pulses; after the INTRO_FRAMES-th pulse, go to ACTIVE.
- ACTIVE: `asteroids_enable` = !`pause`.
  - Each `startOfFrame` (when not paused) increments the sub-second counter. On reaching FRAMES_PER_SECOND, the counter wraps to 0 and `time_left` decrements.
  - Each `asteroid_exploded_pulse` increments `destroyed_count`, saturating at ASTEROIDS_AMOUNT. Pulses are counted regardless of `pause`.
  - Exit conditions, evaluated every cycle, highest priority first:
    - `player_hit` → OUTRO, `stage_won`=0.
    - `all_asteroids_destroied` → OUTRO, `stage_won`=1.
    - `time_left`==0 → OUTRO, `stage_won`=1 (survival win).
- OUTRO: `asteroids_enable`=0. Count OUTRO_FRAMES frames (frozen while `pause`), then go to DONE.
- DONE: `stage_done`=1 for one cycle, then go to IDLE. `stage_won` and `destroyed_count` hold until the next CLEAR.
- `start_stage` is ignored outside IDLE.
- `pause` has no effect in IDLE, CLEAR or DONE.
- Counter widths:
  - Sub-second counter: clog2(FRAMES_PER_SECOND).
  - Phase frame counter: clog2(max(INTRO_FRAMES, OUTRO_FRAMES)+1).
  - `time_left` never wraps below 0.

## Timing
- Reset values:
  - State: IDLE.
  - `asteroids_resetN`=1, `asteroids_enable`=0, `show_intro`=0, `stage_active`=0.
  - `time_left`=0, `destroyed_count`=0, `stage_done`=0, `stage_won`=0.
- All outputs are registered or decoded from registered state, so there is no combinational input→output path.
- Latencies:
  - `start_stage` → `asteroids_resetN` low: 1 cycle.
  - `asteroids_resetN` low → `show_intro` high: 1 cycle.
  - Exit condition → OUTRO: 1 cycle.
- `stage_done` rises exactly OUTRO_FRAMES `startOfFrame` pulses after OUTRO entry, plus 1 cycle.
- `time_left` decrementing to 0 and `player_hit` in the same cycle: the decrement commits, and the stage is lost.
- `asteroid_exploded_pulse` in the same cycle as the ACTIVE→OUTRO transition is still counted.
- Reset asserted mid-stage: immediate return to IDLE with reset values; `stage_done` is not emitted.

## Structure
- Shared package (`game_pkg`) holds:
  - the state enum `asteroid_stage_state_t`;
  - the default frame and second constants, shared with other special stages.
- One sub-module, `frame_timer`: a loadable frame-pulse down-counter with a freeze input and a zero flag. It is instantiated for the phase counter and, with prescaler, for the seconds counter.

## Test plan
- Reset mid-ACTIVE with `time_left`=17 → next cycle in IDLE, all outputs at reset values, no `stage_done`.
- `start_stage` → `asteroids_resetN`=0 for 1 cycle → `show_intro` for 120 frames → `asteroids_enable`=1, `time_left`=30.
- 4 `asteroid_exploded_pulse`, then `all_asteroids_destroied` → `destroyed_count`=4, OUTRO; `stage_done` after 60 frames with `stage_won`=1. A 5th pulse keeps the count at 4.
- No hits for 30×60 frames → `time_left` steps 30…0 once per 60 frames; at 0 → OUTRO, `stage_won`=1.
- `player_hit` and `all_asteroids_destroied` in the same cycle → `stage_won`=0.
- `pause` held 50 frames in ACTIVE → `asteroids_enable`=0 and `time_left` unchanged; release → resumes from the same sub-second count. `start_stage` during ACTIVE is ignored.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared special-stage state type and default frame/second constants
package game_pkg;

    typedef enum logic [2:0] {
        AS_IDLE   = 3'd0,
        AS_CLEAR  = 3'd1,
        AS_INTRO  = 3'd2,
        AS_ACTIVE = 3'd3,
        AS_OUTRO  = 3'd4,
        AS_DONE   = 3'd5
    } asteroid_stage_state_t;

    localparam int DEFAULT_ASTEROIDS_AMOUNT  = 4;
    localparam int DEFAULT_INTRO_FRAMES      = 120;
    localparam int DEFAULT_FRAMES_PER_SECOND = 60;
    localparam int DEFAULT_STAGE_SECONDS     = 30;
    localparam int DEFAULT_OUTRO_FRAMES      = 60;

endpackage

// File: rtl/asteroid_stage_controller_if.sv
// rtl/asteroid_stage_controller_if.sv - game-flow and asteroid-field signals of the stage controller
interface asteroid_stage_controller_if;
    logic       startOfFrame;
    logic       start_stage;
    logic       pause;
    logic       asteroid_exploded_pulse;
    logic       all_asteroids_destroied;
    logic       player_hit;
    logic       asteroids_resetN;
    logic       asteroids_enable;
    logic       show_intro;
    logic       stage_active;
    logic [7:0] time_left;
    logic [3:0] destroyed_count;
    logic       stage_done;
    logic       stage_won;

    modport master (
        input  startOfFrame, start_stage, pause, asteroid_exploded_pulse,
               all_asteroids_destroied, player_hit,
        output asteroids_resetN, asteroids_enable, show_intro, stage_active,
               time_left, destroyed_count, stage_done, stage_won
    );

    modport slave (
        output startOfFrame, start_stage, pause, asteroid_exploded_pulse,
               all_asteroids_destroied, player_hit,
        input  asteroids_resetN, asteroids_enable, show_intro, stage_active,
               time_left, destroyed_count, stage_done, stage_won
    );
endinterface

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - loadable frame-pulse down-counter with prescaler, freeze and zero flag
module frame_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick,
    input  logic             freeze,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    localparam int                SUB_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [SUB_W-1:0] sub_q, sub_d;

    // The count saturates at zero; the prescaler keeps wrapping so a reload starts clean.
    always_comb begin
        count_d = count_q;
        sub_d   = sub_q;
        if (load) begin
            count_d = load_value;
            sub_d   = '0;
        end else if (tick && !freeze) begin
            if (sub_q == SUB_LAST) begin
                sub_d = '0;
                if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end
            end else begin
                sub_d = sub_q + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            sub_q   <= '0;
        end else begin
            count_q <= count_d;
            sub_q   <= sub_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/asteroid_stage_controller.sv
// rtl/asteroid_stage_controller.sv - asteroid special-stage sequencer: arm, intro, timed play, outro, result
module asteroid_stage_controller
    import game_pkg::*;
#(
    parameter int ASTEROIDS_AMOUNT  = DEFAULT_ASTEROIDS_AMOUNT,
    parameter int INTRO_FRAMES      = DEFAULT_INTRO_FRAMES,
    parameter int FRAMES_PER_SECOND = DEFAULT_FRAMES_PER_SECOND,
    parameter int STAGE_SECONDS     = DEFAULT_STAGE_SECONDS,
    parameter int OUTRO_FRAMES      = DEFAULT_OUTRO_FRAMES
) (
    input  logic                          clk,
    input  logic                          reset,
    asteroid_stage_controller_if.master   bus
);

    localparam int         PHASE_MAX     = (INTRO_FRAMES > OUTRO_FRAMES) ? INTRO_FRAMES : OUTRO_FRAMES;
    localparam int         PHASE_W       = $clog2(PHASE_MAX + 1);
    localparam logic [3:0] MAX_DESTROYED = 4'(ASTEROIDS_AMOUNT);

    asteroid_stage_state_t state_q, state_d;
    logic                  won_q, won_d;
    logic [3:0]            destroyed_q, destroyed_d;
    logic                  enable_q, enable_d;

    logic                  exit_active;
    logic                  phase_load;
    logic [PHASE_W-1:0]    phase_load_value;
    logic                  phase_tick;
    logic                  phase_zero;
    logic [PHASE_W-1:0]    phase_count_unused;
    logic                  sec_load;
    logic                  sec_tick;
    logic                  sec_zero;
    logic [7:0]            time_left;

    always_comb begin
        state_d     = state_q;
        won_d       = won_q;
        destroyed_d = destroyed_q;
        exit_active = 1'b0;
        case (state_q)
            AS_IDLE: begin
                if (bus.start_stage) state_d = AS_CLEAR;
            end
            AS_CLEAR: begin
                won_d       = 1'b0;
                destroyed_d = '0;
                state_d     = AS_INTRO;
            end
            AS_INTRO: begin
                if (phase_zero) state_d = AS_ACTIVE;
            end
            AS_ACTIVE: begin
                // Hits still count on the cycle the stage ends.
                if (bus.asteroid_exploded_pulse && (destroyed_q < MAX_DESTROYED)) begin
                    destroyed_d = destroyed_q + 4'd1;
                end
                if (bus.player_hit) begin
                    exit_active = 1'b1;
                    won_d       = 1'b0;
                end else if (bus.all_asteroids_destroied || sec_zero) begin
                    exit_active = 1'b1;
                    won_d       = 1'b1;
                end
                if (exit_active) state_d = AS_OUTRO;
            end
            AS_OUTRO: begin
                if (phase_zero) state_d = AS_DONE;
            end
            AS_DONE: begin
                state_d = AS_IDLE;
            end
            default: begin
                state_d = AS_IDLE;
            end
        endcase
    end

    assign phase_load       = (state_q == AS_CLEAR) || exit_active;
    assign phase_load_value = (state_q == AS_CLEAR) ? PHASE_W'(INTRO_FRAMES) : PHASE_W'(OUTRO_FRAMES);
    assign phase_tick       = bus.startOfFrame && ((state_q == AS_INTRO) || (state_q == AS_OUTRO));
    assign sec_load         = (state_q == AS_CLEAR);
    assign sec_tick         = bus.startOfFrame && (state_q == AS_ACTIVE);
    assign enable_d         = (state_d == AS_ACTIVE) && !bus.pause;

    frame_timer #(
        .WIDTH    (PHASE_W),
        .PRESCALE (1)
    ) u_phase_timer (
        .clk        (clk),
        .rst        (reset),
        .load       (phase_load),
        .load_value (phase_load_value),
        .tick       (phase_tick),
        .freeze     (bus.pause),
        .count      (phase_count_unused),
        .zero       (phase_zero)
    );

    frame_timer #(
        .WIDTH    (8),
        .PRESCALE (FRAMES_PER_SECOND)
    ) u_seconds_timer (
        .clk        (clk),
        .rst        (reset),
        .load       (sec_load),
        .load_value (8'(STAGE_SECONDS)),
        .tick       (sec_tick),
        .freeze     (bus.pause),
        .count      (time_left),
        .zero       (sec_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= AS_IDLE;
            won_q       <= 1'b0;
            destroyed_q <= '0;
            enable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            won_q       <= won_d;
            destroyed_q <= destroyed_d;
            enable_q    <= enable_d;
        end
    end

    assign bus.asteroids_resetN = (state_q != AS_CLEAR);
    assign bus.asteroids_enable = enable_q;
    assign bus.show_intro       = (state_q == AS_INTRO);
    assign bus.stage_active     = (state_q == AS_CLEAR) || (state_q == AS_INTRO) ||
                                  (state_q == AS_ACTIVE) || (state_q == AS_OUTRO);
    assign bus.time_left        = time_left;
    assign bus.destroyed_count  = destroyed_q;
    assign bus.stage_done       = (state_q == AS_DONE);
    assign bus.stage_won        = won_q;

endmodule

// File: tb/tb_asteroid_stage_controller.sv
// tb/tb_asteroid_stage_controller.sv - directed self-checking bench for asteroid_stage_controller
module tb_asteroid_stage_controller;

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic done_seen;

    asteroid_stage_controller_if bus ();

    asteroid_stage_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
        step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_resetN"},    32'(bus.asteroids_resetN), 1);
        chk({tag, "_enable"},    32'(bus.asteroids_enable), 0);
        chk({tag, "_intro"},     32'(bus.show_intro),       0);
        chk({tag, "_active"},    32'(bus.stage_active),     0);
        chk({tag, "_time"},      32'(bus.time_left),        0);
        chk({tag, "_destroyed"}, 32'(bus.destroyed_count),  0);
        chk({tag, "_done"},      32'(bus.stage_done),       0);
        chk({tag, "_won"},       32'(bus.stage_won),        0);
    endtask

    task automatic pulse_hit();
        bus.asteroid_exploded_pulse = 1'b1;
        step();
        bus.asteroid_exploded_pulse = 1'b0;
        step();
    endtask

    task automatic run_to_active(input string tag);
        bus.start_stage = 1'b1;
        step();
        bus.start_stage = 1'b0;
        chk({tag, "_clear_resetN"}, 32'(bus.asteroids_resetN), 0);
        step();
        chk({tag, "_intro_destroyed"}, 32'(bus.destroyed_count), 0);
        chk({tag, "_intro_won"},       32'(bus.stage_won),       0);
        chk({tag, "_intro_time"},      32'(bus.time_left),       30);
        repeat (120) frame();
        chk({tag, "_active_enable"},   32'(bus.asteroids_enable), 1);
    endtask

    initial begin
        reset                       = 1'b1;
        bus.startOfFrame            = 1'b0;
        bus.start_stage             = 1'b0;
        bus.pause                   = 1'b0;
        bus.asteroid_exploded_pulse = 1'b0;
        bus.all_asteroids_destroied = 1'b0;
        bus.player_hit              = 1'b0;
        step();
        step();
        chk_idle("rst");
        reset = 1'b0;
        step();
        chk_idle("idle");

        // Stage 1: arm, intro, pause/resume, hits to saturation, all-destroyed win.
        bus.start_stage = 1'b1;
        step();
        bus.start_stage = 1'b0;
        chk("clear_resetN", 32'(bus.asteroids_resetN), 0);
        chk("clear_active", 32'(bus.stage_active),     1);
        chk("clear_intro",  32'(bus.show_intro),       0);
        step();
        chk("intro_resetN", 32'(bus.asteroids_resetN), 1);
        chk("intro_show",   32'(bus.show_intro),       1);
        chk("intro_time",   32'(bus.time_left),        30);
        chk("intro_enable", 32'(bus.asteroids_enable), 0);
        repeat (119) frame();
        chk("intro119_show",   32'(bus.show_intro),       1);
        chk("intro119_enable", 32'(bus.asteroids_enable), 0);
        frame();
        chk("active_show",   32'(bus.show_intro),       0);
        chk("active_enable", 32'(bus.asteroids_enable), 1);
        chk("active_time",   32'(bus.time_left),        30);

        repeat (10) frame();
        bus.pause = 1'b1;
        step();
        chk("pause_enable", 32'(bus.asteroids_enable), 0);
        repeat (50) frame();
        chk("pause_time",    32'(bus.time_left),        30);
        chk("pause_enable2", 32'(bus.asteroids_enable), 0);
        bus.pause = 1'b0;
        step();
        chk("resume_enable", 32'(bus.asteroids_enable), 1);
        bus.start_stage = 1'b1;
        step();
        bus.start_stage = 1'b0;
        chk("ignored_start_resetN", 32'(bus.asteroids_resetN), 1);
        chk("ignored_start_intro",  32'(bus.show_intro),       0);
        chk("ignored_start_enable", 32'(bus.asteroids_enable), 1);
        repeat (49) frame();
        chk("sub59_time", 32'(bus.time_left), 30);
        frame();
        chk("wrap_time", 32'(bus.time_left), 29);

        repeat (4) pulse_hit();
        chk("four_hits", 32'(bus.destroyed_count), 4);
        pulse_hit();
        chk("sat_hits", 32'(bus.destroyed_count), 4);

        bus.all_asteroids_destroied = 1'b1;
        step();
        bus.all_asteroids_destroied = 1'b0;
        chk("outro_enable", 32'(bus.asteroids_enable), 0);
        chk("outro_won",    32'(bus.stage_won),        1);
        chk("outro_active", 32'(bus.stage_active),     1);
        chk("outro_done",   32'(bus.stage_done),       0);
        repeat (59) frame();
        chk("outro59_done", 32'(bus.stage_done), 0);
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
        chk("outro60_done", 32'(bus.stage_done), 0);
        step();
        chk("done_pulse",     32'(bus.stage_done),      1);
        chk("done_won",       32'(bus.stage_won),       1);
        chk("done_active",    32'(bus.stage_active),    0);
        chk("done_destroyed", 32'(bus.destroyed_count), 4);
        step();
        chk("after_done",      32'(bus.stage_done),      0);
        chk("after_won",       32'(bus.stage_won),       1);
        chk("after_destroyed", 32'(bus.destroyed_count), 4);

        // Stage 2: hit and all-destroyed together lose; a hit pulse on the exit cycle counts.
        run_to_active("s2");
        bus.player_hit              = 1'b1;
        bus.all_asteroids_destroied = 1'b1;
        bus.asteroid_exploded_pulse = 1'b1;
        step();
        bus.player_hit              = 1'b0;
        bus.all_asteroids_destroied = 1'b0;
        bus.asteroid_exploded_pulse = 1'b0;
        chk("s2_won",       32'(bus.stage_won),        0);
        chk("s2_enable",    32'(bus.asteroids_enable), 0);
        chk("s2_active",    32'(bus.stage_active),     1);
        chk("s2_destroyed", 32'(bus.destroyed_count),  1);
        repeat (60) frame();
        chk("s2_done",     32'(bus.stage_done), 1);
        chk("s2_done_won", 32'(bus.stage_won),  0);
        step();

        // Stage 3: survive the full timer.
        run_to_active("s3");
        for (int k = 1; k <= 30; k++) begin
            repeat (60) frame();
            chk($sformatf("s3_time_%0d", k), 32'(bus.time_left), 32'(30 - k));
        end
        chk("s3_enable", 32'(bus.asteroids_enable), 0);
        chk("s3_won",    32'(bus.stage_won),        1);
        chk("s3_active", 32'(bus.stage_active),     1);
        repeat (60) frame();
        chk("s3_done",     32'(bus.stage_done), 1);
        chk("s3_done_won", 32'(bus.stage_won),  1);
        step();

        // Stage 4: last decrement and player hit on the same cycle.
        run_to_active("s4");
        repeat (1799) frame();
        chk("s4_time1",  32'(bus.time_left),        1);
        chk("s4_enable", 32'(bus.asteroids_enable), 1);
        bus.startOfFrame = 1'b1;
        bus.player_hit   = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
        bus.player_hit   = 1'b0;
        chk("s4_time0",   32'(bus.time_left),        0);
        chk("s4_won",     32'(bus.stage_won),        0);
        chk("s4_enable0", 32'(bus.asteroids_enable), 0);
        repeat (60) frame();
        chk("s4_done", 32'(bus.stage_done), 1);
        step();

        // Stage 5: asynchronous reset mid-ACTIVE.
        run_to_active("s5");
        repeat (780) frame();
        chk("s5_time17", 32'(bus.time_left), 17);
        reset = 1'b1;
        #2;
        chk_idle("async_rst");
        step();
        reset = 1'b0;
        step();
        chk_idle("post_rst");
        done_seen = 1'b0;
        repeat (200) begin
            frame();
            if (bus.stage_done) done_seen = 1'b1;
        end
        chk("post_rst_no_done", 32'(done_seen), 0);
        chk("post_rst_active",  32'(bus.stage_active), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
